// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-issue instruction fetch FSM (IDLE/REQ/VALID/HALT) with PC, IR and branch redirect.
// Optional macro FETCH_HALT_ON_ZERO_EN: an all-zero fetched word parks the unit in HALT until reset.
module instr_fetch_unit #(
    parameter int                       DATAWIDTH_BUS = 32,
    parameter logic [DATAWIDTH_BUS-1:0] RESET_PC      = 32'h0000_0800
) (
    input  logic                     CLOCK_50,
    input  logic                     RESET_n,
    input  logic                     Fetch_Enable,
    output logic                     RD,
    output logic                     WR,
    output logic [DATAWIDTH_BUS-1:0] BusDirecciones,
    input  logic [DATAWIDTH_BUS-1:0] BusDatos,
    output logic [DATAWIDTH_BUS-1:0] IR,
    output logic                     IR_Valid,
    input  logic                     IR_Ack,
    input  logic                     Branch_Taken,
    input  logic [21:0]              Branch_Disp,
    output logic [DATAWIDTH_BUS-1:0] PC,
    output logic                     Halted
);
    typedef enum logic [1:0] {IDLE, REQ, VALID, HALT} state_t;

    state_t                   state_q, state_d;
    logic [DATAWIDTH_BUS-1:0] pc_q, pc_d;
    logic [DATAWIDTH_BUS-1:0] ir_q, ir_d;
    logic [DATAWIDTH_BUS-1:0] addr_q, addr_d;
    logic                     rd_q, rd_d;
    logic [DATAWIDTH_BUS-1:0] disp_ext;

    assign disp_ext = {{(DATAWIDTH_BUS-22){Branch_Disp[21]}}, Branch_Disp};

    // Next state, PC redirect and IR capture; RD/address are registered from the next state.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            IDLE: state_d = Fetch_Enable ? REQ : IDLE;
            REQ: begin
                ir_d    = BusDatos;
                state_d = VALID;
`ifdef FETCH_HALT_ON_ZERO_EN
                if (BusDatos == '0) begin
                    ir_d    = '0;
                    state_d = HALT;
                end
`endif
            end
            VALID: begin
                if (IR_Ack) begin
                    pc_d    = Branch_Taken ? pc_q + (disp_ext << 2) : pc_q + DATAWIDTH_BUS'(4);
                    state_d = Fetch_Enable ? REQ : IDLE;
                end
            end
            default: state_d = HALT;
        endcase
        rd_d   = (state_d == REQ);
        addr_d = pc_d;
    end

    // State and datapath registers; reset discards any in-flight fetch.
    always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            addr_q  <= RESET_PC;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
        end
    end

    assign RD             = rd_q;
    assign WR             = 1'b0;
    assign BusDirecciones = addr_q;
    assign IR             = ir_q;
    assign PC             = pc_q;
    assign IR_Valid       = (state_q == VALID);
`ifdef FETCH_HALT_ON_ZERO_EN
    assign Halted         = (state_q == HALT);
`else
    assign Halted         = 1'b0;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench; expected fetch addresses are queued by stimulus and checked by a monitor.
module tb_instr_fetch_unit;
    logic        CLOCK_50 = 1'b0;
    logic        RESET_n;
    logic        Fetch_Enable;
    logic        RD, WR;
    logic [31:0] BusDirecciones, BusDatos, IR, PC;
    logic        IR_Valid, IR_Ack, Branch_Taken, Halted;
    logic [21:0] Branch_Disp;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_addr[$];
    logic [31:0] last_req = 32'h800;
    logic        prev_v = 1'b0;

    instr_fetch_unit dut (
        .CLOCK_50(CLOCK_50), .RESET_n(RESET_n), .Fetch_Enable(Fetch_Enable),
        .RD(RD), .WR(WR), .BusDirecciones(BusDirecciones), .BusDatos(BusDatos),
        .IR(IR), .IR_Valid(IR_Valid), .IR_Ack(IR_Ack), .Branch_Taken(Branch_Taken),
        .Branch_Disp(Branch_Disp), .PC(PC), .Halted(Halted)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Program memory: nonzero everywhere except the halt probe address 0x83C.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h83C) ? 32'h0 : {a[15:0], ~a[15:0]};
    endfunction

    assign BusDatos = mem(BusDirecciones);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every read strobe must match the next queued address; every new IR must match memory.
    always @(negedge CLOCK_50) begin
        if (RESET_n && RD) begin
            if (exp_addr.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_req: got addr %h expected no request at %0t", BusDirecciones, $time);
            end else begin
                last_req = exp_addr.pop_front();
                chk("req_addr", BusDirecciones, last_req);
            end
        end
        if (RESET_n && IR_Valid && !prev_v) begin
            chk("ir_pc", PC, last_req);
            chk("ir_word", IR, mem(last_req));
        end
        prev_v <= IR_Valid;
    end

    task automatic wait_valid(output int n);
        n = 0;
        while (!IR_Valid && n < 20) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (!IR_Valid) begin
            total++;
            bad++;
            $display("FAIL valid_timeout: got IR_Valid=0 expected 1 at %0t", $time);
        end
    endtask

    task automatic ack(input logic bt, input logic [21:0] d);
        IR_Ack = 1'b1;
        Branch_Taken = bt;
        Branch_Disp = d;
        @(posedge CLOCK_50);
        #1;
        IR_Ack = 1'b0;
        Branch_Taken = 1'b0;
        Branch_Disp = 22'h155555;
    endtask

    task automatic step(input logic bt, input logic [21:0] d, input logic [31:0] nxt);
        int n;
        exp_addr.push_back(nxt);
        ack(bt, d);
        wait_valid(n);
        chk("latency", 32'(n), 32'd2);
    endtask

    initial begin
        int n;
        RESET_n = 1'b0;
        Fetch_Enable = 1'b0;
        IR_Ack = 1'b0;
        Branch_Taken = 1'b1;
        Branch_Disp = 22'h3FFFFF;
        repeat (3) @(negedge CLOCK_50);
        chk("rst_pc", PC, 32'h800);
        chk("rst_addr", BusDirecciones, 32'h800);
        chk("rst_ir", IR, 32'h0);
        chk("rst_rd", {31'b0, RD}, 32'h0);
        chk("rst_valid", {31'b0, IR_Valid}, 32'h0);
        chk("rst_halted", {31'b0, Halted}, 32'h0);
        chk("wr", {31'b0, WR}, 32'h0);
        RESET_n = 1'b1;
        // IR_Ack outside VALID must be ignored
        IR_Ack = 1'b1;
        repeat (3) begin
            @(negedge CLOCK_50);
            chk("idle_rd", {31'b0, RD}, 32'h0);
            chk("idle_pc", PC, 32'h800);
        end
        IR_Ack = 1'b0;
        exp_addr.push_back(32'h800);
        Fetch_Enable = 1'b1;
        wait_valid(n);
        step(1'b0, 22'h0, 32'h804);
        // Dropping Fetch_Enable mid-REQ must not abort that fetch
        exp_addr.push_back(32'h808);
        ack(1'b0, 22'h0);
        Fetch_Enable = 1'b0;
        wait_valid(n);
        chk("req_not_aborted", 32'(n), 32'd2);
        ack(1'b0, 22'h0);
        repeat (3) begin
            @(negedge CLOCK_50);
            chk("parked_valid", {31'b0, IR_Valid}, 32'h0);
            chk("parked_pc", PC, 32'h80C);
        end
        exp_addr.push_back(32'h80C);
        Fetch_Enable = 1'b1;
        wait_valid(n);
        for (logic [31:0] a = 32'h810; a <= 32'h820; a += 4) step(1'b0, 22'h0, a);
        step(1'b1, 22'h3FFFFC, 32'h810);
        for (logic [31:0] a = 32'h814; a <= 32'h838; a += 4) step(1'b0, 22'h0, a);
        step(1'b1, 22'h3FFFFB, 32'h824);
        for (logic [31:0] a = 32'h828; a <= 32'h838; a += 4) step(1'b0, 22'h0, a);
        exp_addr.push_back(32'h83C);
        ack(1'b0, 22'h0);
`ifdef FETCH_HALT_ON_ZERO_EN
        repeat (2) @(negedge CLOCK_50);
        chk("halt_halted", {31'b0, Halted}, 32'h1);
        chk("halt_pc", PC, 32'h83C);
        chk("halt_ir", IR, 32'h0);
        chk("halt_valid", {31'b0, IR_Valid}, 32'h0);
        IR_Ack = 1'b1;
        repeat (20) begin
            @(negedge CLOCK_50);
            chk("halt_rd", {31'b0, RD}, 32'h0);
            chk("halt_stays", {31'b0, Halted}, 32'h1);
        end
        IR_Ack = 1'b0;
`else
        wait_valid(n);
        chk("zero_ir", IR, 32'h0);
        chk("zero_valid", {31'b0, IR_Valid}, 32'h1);
        chk("zero_halted", {31'b0, Halted}, 32'h0);
`endif
        @(negedge CLOCK_50);
        RESET_n = 1'b0;
        #1;
        chk("rerst_pc", PC, 32'h800);
        chk("rerst_halted", {31'b0, Halted}, 32'h0);
        @(negedge CLOCK_50);
        exp_addr.push_back(32'h800);
        RESET_n = 1'b1;
        wait_valid(n);
        step(1'b1, 22'h3FFDFF, 32'hFFFF_FFFC);
        step(1'b0, 22'h0, 32'h0);
        // Stall: no ack for 10 cycles, branch inputs toggling must be ignored
        Branch_Taken = 1'b1;
        repeat (10) begin
            @(negedge CLOCK_50);
            Branch_Disp = 22'h2AAAAA;
            chk("stall_ir", IR, mem(32'h0));
            chk("stall_pc", PC, 32'h0);
            chk("stall_rd", {31'b0, RD}, 32'h0);
            chk("stall_valid", {31'b0, IR_Valid}, 32'h1);
        end
        step(1'b1, 22'h000205, 32'h814);
        chk("pre_reset_pc", PC, 32'h814);
        #2;
        RESET_n = 1'b0;
        #1;
        chk("midrst_valid", {31'b0, IR_Valid}, 32'h0);
        chk("midrst_pc", PC, 32'h800);
        chk("midrst_addr", BusDirecciones, 32'h800);
        chk("midrst_ir", IR, 32'h0);
        chk("midrst_rd", {31'b0, RD}, 32'h0);
        chk("pending_reqs", 32'(exp_addr.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
